// File: rtl/gpio_mailbox_ctrl.sv
// Byte sequencer between the host register side and the PULPino GPIO mailbox (data + flicker toggles).
// Optional MBOX_STATS_EN adds acked-TX / captured-RX byte counters.
module gpio_mailbox_ctrl #(
    parameter int pDEPTH    = 16,
    parameter int pTO_WIDTH = 16
) (
    input  logic                      crypto_clk,
    input  logic                      reset_i,
    input  logic [7:0]                I_tx_data,
    input  logic                      I_tx_valid,
    output logic                      O_tx_ready,
    input  logic                      I_rx_ready,
    output logic [7:0]                O_rx_data,
    output logic                      O_rx_valid,
    input  logic [pTO_WIDTH-1:0]      I_to_limit,
    input  logic                      I_clear,
    output logic                      O_timeout,
    output logic [$clog2(pDEPTH):0]   O_tx_level,
    output logic                      O_busy,
`ifdef MBOX_STATS_EN
    output logic [15:0]               O_tx_count,
    output logic [15:0]               O_rx_count,
`endif
    output logic [7:0]                O_ext_data,
    output logic                      O_ext_write_flicker,
    output logic                      O_ext_read_flicker,
    input  logic [7:0]                I_pulpino_data,
    input  logic                      I_pulpino_read_flicker,
    input  logic                      I_pulpino_write_flicker
);
    localparam int AW = $clog2(pDEPTH);
    localparam int LW = AW + 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PRESENT = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;

    logic [7:0]           mem [pDEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [LW-1:0]        level;
    logic [1:0]           state;
    logic [pTO_WIDTH-1:0] to_cnt;
    logic                 rf_q, wf_q, pending;
    logic                 push, pop, rf_event, wf_event, to_hit, timeout_set, tx_ack, capture;

    // Flicker inputs are already in crypto_clk, so a single registered copy gives the edge.
    assign rf_event = I_pulpino_read_flicker ^ rf_q;
    assign wf_event = I_pulpino_write_flicker ^ wf_q;

    assign pop  = (state == S_PRESENT);
    // A pop in PRESENT frees a slot this cycle, so a full FIFO can still accept a push.
    assign O_tx_ready = (level != LW'(pDEPTH)) || pop;
    assign push = I_tx_valid && O_tx_ready;
    assign O_tx_level = level;
    assign O_busy = (state != S_IDLE);

    assign to_hit      = (I_to_limit != '0) && (to_cnt == I_to_limit - pTO_WIDTH'(1));
    assign tx_ack      = (state == S_WAIT) && rf_event;
    assign timeout_set = (state == S_WAIT) && !rf_event && to_hit;

    // While a byte is pending, rx_valid is necessarily set, so host ready alone releases it.
    assign capture = pending ? I_rx_ready : (wf_event && (!O_rx_valid || I_rx_ready));

    always_ff @(posedge crypto_clk) begin
        if (push) mem[wr_ptr] <= I_tx_data;
    end

    always_ff @(posedge crypto_clk or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge crypto_clk or posedge reset_i) begin
        if (reset_i) begin
            state               <= S_IDLE;
            to_cnt              <= '0;
            O_ext_data          <= '0;
            O_ext_write_flicker <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (level != '0) state <= S_PRESENT;
                S_PRESENT: begin
                    O_ext_data          <= mem[rd_ptr];
                    O_ext_write_flicker <= ~O_ext_write_flicker;
                    to_cnt              <= '0;
                    state               <= S_WAIT;
                end
                S_WAIT: begin
                    if (rf_event || to_hit) state <= S_IDLE;
                    else                    to_cnt <= to_cnt + pTO_WIDTH'(1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge crypto_clk or posedge reset_i) begin
        if (reset_i)          O_timeout <= 1'b0;
        else if (timeout_set) O_timeout <= 1'b1;
        else if (I_clear)     O_timeout <= 1'b0;
    end

    always_ff @(posedge crypto_clk or posedge reset_i) begin
        if (reset_i) begin
            rf_q               <= 1'b0;
            wf_q               <= 1'b0;
            pending            <= 1'b0;
            O_rx_data          <= '0;
            O_rx_valid         <= 1'b0;
            O_ext_read_flicker <= 1'b0;
        end else begin
            rf_q <= I_pulpino_read_flicker;
            wf_q <= I_pulpino_write_flicker;
            if (capture) begin
                O_rx_data          <= I_pulpino_data;
                O_rx_valid         <= 1'b1;
                O_ext_read_flicker <= ~O_ext_read_flicker;
                pending            <= 1'b0;
            end else if (wf_event && !pending) begin
                pending <= 1'b1;
            end else if (I_rx_ready) begin
                O_rx_valid <= 1'b0;
            end
        end
    end

`ifdef MBOX_STATS_EN
    always_ff @(posedge crypto_clk or posedge reset_i) begin
        if (reset_i) begin
            O_tx_count <= '0;
            O_rx_count <= '0;
        end else if (I_clear) begin
            O_tx_count <= '0;
            O_rx_count <= '0;
        end else begin
            if (tx_ack)  O_tx_count <= O_tx_count + 16'd1;
            if (capture) O_rx_count <= O_rx_count + 16'd1;
        end
    end
`endif

endmodule
